// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared CORDIC definitions: FSM states, iteration limit and
//                the arctangent table scaled so that 2^(DSIZE-1) equals 180 deg.
//  Revision    : 1.0  initial release
// ============================================================================
package cordic_pkg;

    localparam int ITER_MAX = 16;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cordic_state_t;

    // Reference table holds atan(2^-i) with 2^31 = 180 deg; narrower widths
    // are derived by a rounded right shift.
    function automatic logic [31:0] atan_lsb(input int dsize, input int idx);
        logic [63:0] v;
        case (idx)
            0:       v = 64'd536870912;
            1:       v = 64'd316933406;
            2:       v = 64'd167458907;
            3:       v = 64'd85004756;
            4:       v = 64'd42667331;
            5:       v = 64'd21354465;
            6:       v = 64'd10679838;
            7:       v = 64'd5340245;
            8:       v = 64'd2670163;
            9:       v = 64'd1335087;
            10:      v = 64'd667544;
            11:      v = 64'd333772;
            12:      v = 64'd166886;
            13:      v = 64'd83443;
            14:      v = 64'd41722;
            15:      v = 64'd20861;
            default: v = 64'd0;
        endcase
        if (dsize < 32) begin
            v = (v + (64'd1 << (31 - dsize))) >> (32 - dsize);
        end
        return v[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_microrot.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_microrot
//  Description : Combinational single CORDIC micro-rotation (rotation mode).
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_microrot
    import cordic_pkg::*;
#(
    parameter int DSIZE = 16
) (
    input  logic signed [DSIZE+1:0] i_x,
    input  logic signed [DSIZE+1:0] i_y,
    input  logic signed [DSIZE:0]   i_z,
    input  logic        [CNT_W-1:0] i_i,
    input  logic signed [DSIZE:0]   i_atan,
    output logic signed [DSIZE+1:0] o_x,
    output logic signed [DSIZE+1:0] o_y,
    output logic signed [DSIZE:0]   o_z
);

    logic signed [DSIZE+1:0] w_x_sh;
    logic signed [DSIZE+1:0] w_y_sh;

    assign w_x_sh = i_x >>> i_i;
    assign w_y_sh = i_y >>> i_i;

    // Rotate toward driving the residual angle to zero; z == 0 counts as positive.
    always_comb begin
        if (!i_z[DSIZE]) begin
            o_x = i_x - w_y_sh;
            o_y = i_y + w_x_sh;
            o_z = i_z - i_atan;
        end else begin
            o_x = i_x + w_y_sh;
            o_y = i_y - w_x_sh;
            o_z = i_z + i_atan;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_rotate_iter.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_rotate_iter
//  Description : Iterative rotation-mode CORDIC, one micro-rotation per clock,
//                valid/ready on both sides, one operand set in flight.
//                Define CORDIC_QUAD_EN for quadrant pre-rotation (+/-180 deg).
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_rotate_iter
    import cordic_pkg::*;
#(
    parameter int DSIZE = 16,
    parameter int ITER  = 16
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DSIZE-1:0] x_in,
    input  logic signed [DSIZE-1:0] y_in,
    input  logic signed [DSIZE-1:0] angle,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DSIZE+1:0] x_out,
    output logic signed [DSIZE+1:0] y_out
);

    localparam int XW = DSIZE + 2;
    localparam int ZW = DSIZE + 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ITER - 1);

    cordic_state_t            r_state;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic signed [XW-1:0]     r_x;
    logic signed [XW-1:0]     r_y;
    logic signed [ZW-1:0]     r_z;
    logic        [CNT_W-1:0]  r_cnt;

    logic signed [ZW-1:0]     w_atan_tab [ITER_MAX];
    logic signed [XW-1:0]     w_x_ext;
    logic signed [XW-1:0]     w_y_ext;
    logic signed [ZW-1:0]     w_z_ext;
    logic signed [XW-1:0]     w_ld_x;
    logic signed [XW-1:0]     w_ld_y;
    logic signed [ZW-1:0]     w_ld_z;
    logic signed [XW-1:0]     w_nx;
    logic signed [XW-1:0]     w_ny;
    logic signed [ZW-1:0]     w_nz;

    for (genvar g = 0; g < ITER_MAX; g++) begin : g_atan
        localparam logic [31:0] c_ATAN = atan_lsb(DSIZE, g);
        assign w_atan_tab[g] = ZW'(c_ATAN);
    end

    assign w_x_ext = {{2{x_in[DSIZE-1]}}, x_in};
    assign w_y_ext = {{2{y_in[DSIZE-1]}}, y_in};
    assign w_z_ext = {angle[DSIZE-1], angle};

`ifdef CORDIC_QUAD_EN
    localparam logic signed [ZW-1:0] c_QUARTER = ZW'(2 ** (DSIZE - 2));

    // An exact +/-90 deg swap brings the residual angle into CORDIC's range.
    always_comb begin
        w_ld_x = w_x_ext;
        w_ld_y = w_y_ext;
        w_ld_z = w_z_ext;
        if (w_z_ext > c_QUARTER) begin
            w_ld_x = -w_y_ext;
            w_ld_y = w_x_ext;
            w_ld_z = w_z_ext - c_QUARTER;
        end else if (w_z_ext < -c_QUARTER) begin
            w_ld_x = w_y_ext;
            w_ld_y = -w_x_ext;
            w_ld_z = w_z_ext + c_QUARTER;
        end
    end
`else
    assign w_ld_x = w_x_ext;
    assign w_ld_y = w_y_ext;
    assign w_ld_z = w_z_ext;
`endif

    cordic_microrot #(
        .DSIZE (DSIZE)
    ) u_microrot (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_z    (r_z),
        .i_i    (r_cnt),
        .i_atan (w_atan_tab[r_cnt]),
        .o_x    (w_nx),
        .o_y    (w_ny),
        .o_z    (w_nz)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_x        <= w_ld_x;
                        r_y        <= w_ld_y;
                        r_z        <= w_ld_z;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_x   <= w_nx;
                    r_y   <= w_ny;
                    r_z   <= w_nz;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign x_out     = r_x;
    assign y_out     = r_y;

endmodule
`default_nettype wire
